// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, single-outstanding imem fetch and IF_IR/IF_PC registers
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_taken,
    input  logic [31:0] trap_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_IR,
    output logic [31:0] IF_PC,
    output logic        IF_valid
);
    typedef enum logic [2:0] {RST, ISSUE, WAIT, HOLD, DROP} state_t;
    state_t state;
    logic [31:0] pc_q, hold_buf, target, pc_next;
    logic redirect;
    assign redirect  = trap_taken | br_taken;
    assign target    = (trap_taken ? trap_target : br_target) & ~32'd3;
    assign pc_next   = pc_q + 32'd4;
    assign imem_req  = (state == ISSUE) && !redirect;
    assign imem_addr = pc_q;
    // Fetch FSM: redirects flush everything; otherwise load, buffer under stall, or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST;
            pc_q     <= RESET_PC;
            hold_buf <= 32'd0;
            IF_IR    <= NOP_INSTR;
            IF_PC    <= 32'd0;
            IF_valid <= 1'b0;
        end else if (redirect) begin
            pc_q     <= target;
            IF_IR    <= NOP_INSTR;
            IF_valid <= 1'b0;
            state    <= (state == WAIT || state == DROP) ? (imem_rvalid ? ISSUE : DROP) : ISSUE;
        end else begin
            if (!stall) begin
                IF_IR    <= NOP_INSTR;
                IF_valid <= 1'b0;
            end
            case (state)
                RST:   state <= ISSUE;
                ISSUE: state <= WAIT;
                WAIT:
                    if (imem_rvalid) begin
                        if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            IF_IR    <= imem_rdata;
                            IF_PC    <= pc_q;
                            IF_valid <= 1'b1;
                            pc_q     <= pc_next;
                            state    <= ISSUE;
                        end
                    end
                HOLD:
                    if (!stall) begin
                        IF_IR    <= hold_buf;
                        IF_PC    <= pc_q;
                        IF_valid <= 1'b1;
                        pc_q     <= pc_next;
                        state    <= ISSUE;
                    end
                DROP:    if (imem_rvalid) state <= ISSUE;
                default: state <= ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors plus corner sequences against a latency-configurable imem model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0, rst = 1, stall = 0, br_taken = 0, trap_taken = 0;
    logic [31:0] br_target = 0, trap_target = 0;
    logic imem_req, imem_rvalid, IF_valid;
    logic [31:0] imem_addr, imem_rdata, IF_IR, IF_PC;
    int checks = 0, failures = 0;
    int lat = 1;
    logic pend;
    int cnt;
    logic [31:0] paddr;
    bit ok;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .trap_taken(trap_taken), .trap_target(trap_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_IR(IF_IR), .IF_PC(IF_PC), .IF_valid(IF_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a + 32'h1000_0003;
    endfunction

    // Instruction memory: one response lat cycles after each request, reset with the DUT
    assign imem_rvalid = pend && cnt == 1;
    assign imem_rdata  = imem_rvalid ? f(paddr) : 32'hDEAD_BEEF;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 0;
            cnt   <= 0;
            paddr <= 0;
        end else if (imem_req) begin
            pend  <= 1;
            cnt   <= lat;
            paddr <= imem_addr;
        end else if (imem_rvalid) pend <= 0;
        else if (pend) cnt <= cnt - 1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit found);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (imem_req) found = 1;
            else next_cycle();
        end
    endtask

    task automatic wait_valid(output bit found);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (IF_valid) found = 1;
            else next_cycle();
        end
    endtask

    typedef struct {
        logic st, br;
        logic [31:0] bt;
        logic tr;
        logic [31:0] tt;
        logic req;
        logic [31:0] addr, ir, pc;
        logic v;
    } vec_t;
    vec_t vecs[18];

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 1, 32'h0, NOP, 32'h0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 1, 32'h4, f(32'h0), 32'h0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 32'h4, NOP, 32'h0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 32'h8, f(32'h4), 32'h4, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 32'h8, NOP, 32'h4, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 32'hC, f(32'h8), 32'h8, 1};
        vecs[8]  = '{0, 1, 32'h101, 0, 0, 0, 32'hC, NOP, 32'h8, 0};
        vecs[9]  = '{0, 1, 32'h200, 1, 32'h82, 0, 32'h100, NOP, 32'h8, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 32'h80, NOP, 32'h8, 0};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 32'h80, NOP, 32'h8, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 0, 32'h80, NOP, 32'h8, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 0, 32'h80, NOP, 32'h8, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 32'h80, NOP, 32'h8, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 1, 32'h84, f(32'h80), 32'h80, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 32'h84, f(32'h80), 32'h80, 1};
        vecs[17] = '{0, 0, 0, 0, 0, 1, 32'h88, f(32'h84), 32'h84, 1};
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].st; br_taken = vecs[i].br; br_target = vecs[i].bt;
            trap_taken = vecs[i].tr; trap_target = vecs[i].tt;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), imem_req, vecs[i].req);
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_ir", i), IF_IR, vecs[i].ir);
            chk($sformatf("v%0d_pc", i), IF_PC, vecs[i].pc);
            chk($sformatf("v%0d_valid", i), IF_valid, vecs[i].v);
            next_cycle();
        end
        stall = 0; br_taken = 0; trap_taken = 0;
        // Branch while WAIT with a late response: data must be dropped
        lat = 3;
        wait_req(ok);
        chk("drop_req_timeout", ok, 1);
        next_cycle();
        br_taken = 1; br_target = 32'h300;
        @(negedge clk);
        chk("drop_wait_req", imem_req, 0);
        chk("drop_wait_valid", IF_valid, 0);
        next_cycle();
        br_taken = 0;
        @(negedge clk);
        chk("drop_a_req", imem_req, 0);
        next_cycle();
        @(negedge clk);
        chk("drop_b_req", imem_req, 0);
        chk("drop_b_valid", IF_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("drop_next_req", imem_req, 1);
        chk("drop_next_addr", imem_addr, 32'h300);
        next_cycle();
        wait_valid(ok);
        chk("drop_valid_timeout", ok, 1);
        chk("drop_ir", IF_IR, f(32'h300));
        chk("drop_pc", IF_PC, 32'h300);
        // PC wrap at top of address space via an unaligned trap target
        lat = 1;
        next_cycle();
        trap_taken = 1; trap_target = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("wrap_trap_req", imem_req, 0);
        next_cycle();
        trap_taken = 0;
        wait_req(ok);
        chk("wrap_req_timeout", ok, 1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        wait_valid(ok);
        chk("wrap_valid_timeout", ok, 1);
        chk("wrap_pc", IF_PC, 32'hFFFF_FFFC);
        chk("wrap_ir", IF_IR, f(32'hFFFF_FFFC));
        chk("wrap_next_req", imem_req, 1);
        chk("wrap_next_addr", imem_addr, 32'h0);
        // Asynchronous reset in the middle of WAIT
        lat = 2;
        next_cycle();
        #2 rst = 1;
        #1;
        chk("rst_ir", IF_IR, NOP);
        chk("rst_pc", IF_PC, 32'h0);
        chk("rst_valid", IF_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        lat = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("rst_c0_req", imem_req, 0);
        next_cycle();
        @(negedge clk);
        chk("rst_c1_req", imem_req, 1);
        chk("rst_c1_addr", imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rst_c2_valid", IF_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("rst_c3_valid", IF_valid, 1);
        chk("rst_c3_ir", IF_IR, f(32'h0));
        chk("rst_c3_pc", IF_PC, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
